// File: rtl/cpu_debug_master.sv
// Debug-port initiator for the pipelined CPU: block load/dump of instruction memory,
// data memory and register file, plus run/step/halt control through a clock enable.
module cpu_debug_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [8:0]        cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              inst_we,
    output logic              data_we,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] inst_in,
    output logic [DATA_W-1:0] data_in,
    output logic              rf_dcp_rd,
    output logic [RF_AW-1:0]  rf_addr,
    input  logic [DATA_W-1:0] inst_out,
    input  logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] rf_out,
    input  logic              cpu_stop,
    output logic              cpu_clk_en,
    output logic              busy,
    output logic [CNT_W-1:0]  cycles,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD_ADDR, S_RD_CAP, S_RD_OUT, S_RUN, S_STEP
    } state_e;

    typedef enum logic [2:0] {
        OP_WR_INST = 3'd0, OP_WR_DATA = 3'd1, OP_RD_INST = 3'd2, OP_RD_DATA = 3'd3,
        OP_RD_RF   = 3'd4, OP_RUN     = 3'd5, OP_STEP    = 3'd6, OP_HALT    = 3'd7
    } op_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [8:0]          len_q, len_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                wdata_ready_q, wdata_ready_d;
    logic                rdata_valid_q, rdata_valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                inst_we_q, inst_we_d;
    logic                data_we_q, data_we_d;
    logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
    logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
    logic [DATA_W-1:0]   inst_in_q, inst_in_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;
    logic                rf_dcp_rd_q, rf_dcp_rd_d;
    logic [RF_AW-1:0]    rf_addr_q, rf_addr_d;
    logic                cpu_clk_en_q, cpu_clk_en_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;
    logic                err_q, err_d;
    logic                load_rd;

    logic cmd_acc, wr_acc, rd_acc;
    assign cmd_acc = cmd_valid & cmd_ready_q;
    assign wr_acc  = wdata_valid & wdata_ready_q;
    assign rd_acc  = rdata_valid_q & rdata_ready;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        len_d       = len_q;
        rdata_d     = rdata_q;
        inst_addr_d = inst_addr_q;
        data_addr_d = data_addr_q;
        rf_addr_d   = rf_addr_q;
        inst_in_d   = inst_in_q;
        data_in_d   = data_in_q;
        inst_we_d   = 1'b0;
        data_we_d   = 1'b0;
        err_d       = 1'b0;
        load_rd     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    op_d   = op_e'(cmd_op);
                    addr_d = cmd_addr;
                    len_d  = cmd_len;
                    case (op_e'(cmd_op))
                        OP_WR_INST, OP_WR_DATA: if (cmd_len != '0) state_d = S_WR;
                        OP_RD_INST, OP_RD_DATA, OP_RD_RF: begin
                            if (cmd_len != '0) begin
                                state_d = S_RD_ADDR;
                                load_rd = 1'b1;
                            end
                        end
                        // A CPU already stopped gets no enabled cycles at all.
                        OP_RUN:  if (!cpu_stop) state_d = S_RUN;
                        OP_STEP: state_d = S_STEP;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_WR: begin
                if (wr_acc) begin
                    if (op_q == OP_WR_INST) begin
                        inst_we_d   = 1'b1;
                        inst_addr_d = addr_q;
                        inst_in_d   = wdata;
                    end else begin
                        data_we_d   = 1'b1;
                        data_addr_d = addr_q;
                        data_in_d   = wdata;
                    end
                    addr_d = addr_q + ADDR_W'(1);
                    len_d  = len_q - 9'd1;
                    if (len_q == 9'd1) state_d = S_IDLE;
                end
            end
            S_RD_ADDR: state_d = S_RD_CAP;
            S_RD_CAP: begin
                case (op_q)
                    OP_RD_INST: rdata_d = inst_out;
                    OP_RD_DATA: rdata_d = data_out;
                    default:    rdata_d = rf_out;
                endcase
                state_d = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (rd_acc) begin
                    addr_d = addr_q + ADDR_W'(1);
                    len_d  = len_q - 9'd1;
                    if (len_q == 9'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RD_ADDR;
                        load_rd = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (cmd_acc) begin
                    if (op_e'(cmd_op) == OP_HALT) state_d = S_IDLE;
                    else                          err_d   = 1'b1;
                end
                if (cpu_stop) state_d = S_IDLE;
            end
            S_STEP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Read addresses are registered on entry to RD_ADDR so they are stable through RD_CAP.
        if (load_rd) begin
            case (op_d)
                OP_RD_INST: inst_addr_d = addr_d;
                OP_RD_DATA: data_addr_d = addr_d;
                default:    rf_addr_d   = addr_d[RF_AW-1:0];
            endcase
        end

        cmd_ready_d   = (state_d == S_IDLE) || (state_d == S_RUN);
        wdata_ready_d = (state_d == S_WR);
        rdata_valid_d = (state_d == S_RD_OUT);
        rf_dcp_rd_d   = ((state_d == S_RD_ADDR) || (state_d == S_RD_CAP) ||
                         (state_d == S_RD_OUT)) && (op_d == OP_RD_RF);
        cpu_clk_en_d  = (state_d == S_RUN) || (state_d == S_STEP);
        busy_d        = (state_d != S_IDLE);
        cycles_d      = cycles_q + CNT_W'(cpu_clk_en_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= OP_WR_INST;
            addr_q        <= '0;
            len_q         <= '0;
            cmd_ready_q   <= 1'b1;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            inst_we_q     <= 1'b0;
            data_we_q     <= 1'b0;
            inst_addr_q   <= '0;
            data_addr_q   <= '0;
            inst_in_q     <= '0;
            data_in_q     <= '0;
            rf_dcp_rd_q   <= 1'b0;
            rf_addr_q     <= '0;
            cpu_clk_en_q  <= 1'b0;
            busy_q        <= 1'b0;
            cycles_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            cmd_ready_q   <= cmd_ready_d;
            wdata_ready_q <= wdata_ready_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
            inst_we_q     <= inst_we_d;
            data_we_q     <= data_we_d;
            inst_addr_q   <= inst_addr_d;
            data_addr_q   <= data_addr_d;
            inst_in_q     <= inst_in_d;
            data_in_q     <= data_in_d;
            rf_dcp_rd_q   <= rf_dcp_rd_d;
            rf_addr_q     <= rf_addr_d;
            cpu_clk_en_q  <= cpu_clk_en_d;
            busy_q        <= busy_d;
            cycles_q      <= cycles_d;
            err_q         <= err_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata       = rdata_q;
    assign inst_we     = inst_we_q;
    assign data_we     = data_we_q;
    assign inst_addr   = inst_addr_q;
    assign data_addr   = data_addr_q;
    assign inst_in     = inst_in_q;
    assign data_in     = data_in_q;
    assign rf_dcp_rd   = rf_dcp_rd_q;
    assign rf_addr     = rf_addr_q;
    assign cpu_clk_en  = cpu_clk_en_q;
    assign busy        = busy_q;
    assign cycles      = cycles_q;
    assign err         = err_q;

endmodule
